rank_match_scheduler: RTL and testbench

RANK_MATCH_SCHEDULER -- requirements
Module: rank_match_scheduler

---
 rtl/card_match_pkg.sv | 18 +
 rtl/score_argmin.sv | 31 +++
 rtl/rank_match_scheduler.sv | 131 +++++++++++++
 tb/tb_rank_match_scheduler.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_match_pkg.sv
// Shared types and sizing for the card rank matcher.
// Kernel count, score width and FSM encoding live here.
package card_match_pkg;

  localparam int NUM_KERNELS = 13;
  localparam int SCORE_W     = 11;
  localparam int RANK_W      = 4;

  localparam logic [RANK_W-1:0] RANK_NONE = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/score_argmin.sv
// Running minimum over kernel scores; strict compare so ties
// keep the earliest kernel.
module score_argmin
  import card_match_pkg::*;
#(
  parameter int SCORE_W = card_match_pkg::SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               valid,
  input  logic [RANK_W-1:0]  idx,
  input  logic [SCORE_W-1:0] score,
  output logic [RANK_W-1:0]  best_idx,
  output logic [SCORE_W-1:0] best_score
);

  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx   <= '0;
      best_score <= '1;
    end else if (clear) begin
      best_idx   <= '0;
      best_score <= '1;
    end else if (valid && score < best_score) begin
      best_idx   <= idx;
      best_score <= score;
    end
  end

endmodule

// File: rtl/rank_match_scheduler.sv
// Sequences one XOR scoring pass per rank kernel and reports
// the best-matching rank, with a per-kernel watchdog.
module rank_match_scheduler
  import card_match_pkg::*;
#(
  parameter int NUM_KERNELS    = card_match_pkg::NUM_KERNELS,
  parameter int SCORE_W        = card_match_pkg::SCORE_W,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture_done,
  input  logic [SCORE_W-1:0] match_thresh,
  output logic               eng_start,
  output logic [RANK_W-1:0]  eng_kernel_sel,
  input  logic               eng_score_valid,
  input  logic [SCORE_W-1:0] eng_score,
  output logic               busy,
  output logic               result_valid,
  output logic [RANK_W-1:0]  result_rank,
  output logic [SCORE_W-1:0] result_score,
  output logic               no_match,
  output logic               err_timeout,
  output logic               overrun
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RANK_W-1:0] LAST =
    RANK_W'(NUM_KERNELS - 1);
  localparam logic [CNT_W-1:0] T_MAX =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [SCORE_W-1:0] thresh;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timed_out;
  logic [RANK_W-1:0]  best_idx;
  logic [SCORE_W-1:0] best_score;
  logic               accept;
  logic               hit;
  logic               expire;
  logic               miss;

  assign accept    = capture_done && (state == ST_IDLE);
  assign hit       = (state == ST_WAIT) && eng_score_valid;
  assign expire    = (state == ST_WAIT) && !eng_score_valid &&
                     (wait_cnt == T_MAX);
  assign eng_start = (state == ST_LAUNCH);
  assign busy      = (state != ST_IDLE);
  assign miss      = timed_out || (best_score > thresh);

  score_argmin #(
    .SCORE_W (SCORE_W)
  ) u_argmin (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .valid      (hit),
    .idx        (eng_kernel_sel),
    .score      (eng_score),
    .best_idx   (best_idx),
    .best_score (best_score)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      eng_kernel_sel <= '0;
      thresh         <= '0;
      wait_cnt       <= '0;
      timed_out      <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (capture_done) begin
            state          <= ST_LAUNCH;
            eng_kernel_sel <= '0;
            thresh         <= match_thresh;
            timed_out      <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (hit) begin
            if (eng_kernel_sel == LAST) begin
              state <= ST_FINISH;
            end else begin
              state          <= ST_LAUNCH;
              eng_kernel_sel <= eng_kernel_sel + 1'b1;
            end
          end else if (expire) begin
            state     <= ST_FINISH;
            timed_out <= 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
      // A dropped capture wins over nothing; an accepted one clears.
      if (accept) begin
        overrun <= 1'b0;
      end else if (capture_done) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid <= 1'b0;
      result_rank  <= RANK_NONE;
      result_score <= '0;
      no_match     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      result_valid <= (state == ST_FINISH);
      if (state == ST_FINISH) begin
        result_score <= best_score;
        err_timeout  <= timed_out;
        no_match     <= miss;
        result_rank  <= miss ? RANK_NONE : best_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rank_match_scheduler.sv
// Directed bench: two schedulers (default and short watchdog)
// each driven by a behavioural scoring engine.
module tb_rank_match_scheduler;

  logic        clk;
  logic        rst;
  int          cyc = 0;

  logic        a_cap, a_start, a_esv, a_busy, a_rv;
  logic        a_nm, a_et, a_ov;
  logic [10:0] a_thr, a_esc, a_rs;
  logic [3:0]  a_sel, a_rr;
  logic        b_cap, b_start, b_esv, b_busy, b_rv;
  logic        b_nm, b_et, b_ov;
  logic [10:0] b_thr, b_esc, b_rs;
  logic [3:0]  b_sel, b_rr;

  int          a_lat, b_lat, a_silent, b_silent;
  logic [10:0] a_tbl [13];
  logic [10:0] b_tbl [13];
  logic        a_stray;
  int          a_cd = 0, b_cd = 0;

  int          a_rv_n = 0, a_rv_cyc = 0, a_st_n = 0;
  int          b_rv_n = 0, b_rv_cyc = 0, b_st7_cyc = 0;
  int          cap_cyc;
  int          nvec = 0, nmis = 0;

  rank_match_scheduler u_a (
    .clk             (clk),
    .rst             (rst),
    .capture_done    (a_cap),
    .match_thresh    (a_thr),
    .eng_start       (a_start),
    .eng_kernel_sel  (a_sel),
    .eng_score_valid (a_esv),
    .eng_score       (a_esc),
    .busy            (a_busy),
    .result_valid    (a_rv),
    .result_rank     (a_rr),
    .result_score    (a_rs),
    .no_match        (a_nm),
    .err_timeout     (a_et),
    .overrun         (a_ov)
  );

  rank_match_scheduler #(
    .TIMEOUT_CYCLES (16)
  ) u_b (
    .clk             (clk),
    .rst             (rst),
    .capture_done    (b_cap),
    .match_thresh    (b_thr),
    .eng_start       (b_start),
    .eng_kernel_sel  (b_sel),
    .eng_score_valid (b_esv),
    .eng_score       (b_esc),
    .busy            (b_busy),
    .result_valid    (b_rv),
    .result_rank     (b_rr),
    .result_score    (b_rs),
    .no_match        (b_nm),
    .err_timeout     (b_et),
    .overrun         (b_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine answers in the (L+1)th cycle after the eng_start cycle.
  always @(negedge clk) begin
    a_esv = 1'b0;
    if (a_stray) begin
      a_esv = 1'b1;
      a_esc = 11'd0;
    end
    if (a_cd > 0) begin
      a_cd--;
      if (a_cd == 0 && int'(a_sel) != a_silent) begin
        a_esv = 1'b1;
        a_esc = a_tbl[a_sel];
      end
    end
    if (a_start) a_cd = a_lat + 1;
  end

  always @(negedge clk) begin
    b_esv = 1'b0;
    if (b_cd > 0) begin
      b_cd--;
      if (b_cd == 0 && int'(b_sel) != b_silent) begin
        b_esv = 1'b1;
        b_esc = b_tbl[b_sel];
      end
    end
    if (b_start) b_cd = b_lat + 1;
  end

  always @(negedge clk) begin
    if (a_rv) begin
      a_rv_n++;
      a_rv_cyc = cyc;
    end
    if (a_start) a_st_n++;
    if (b_rv) begin
      b_rv_n++;
      b_rv_cyc = cyc;
    end
    if (b_start && b_sel == 4'd7) b_st7_cyc = cyc;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_cap(input logic [10:0] th);
    a_thr   = th;
    a_cap   = 1'b1;
    cap_cyc = cyc;
    @(negedge clk);
    a_cap = 1'b0;
  endtask

  task automatic wait_rv(input int budget);
    int n0 = a_rv_n;
    int i  = 0;
    while (a_rv_n == n0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("rv_seen", a_rv_n - n0, 1);
  endtask

  task automatic wait_sel(input logic [3:0] s);
    int i = 0;
    while (!(a_busy && !a_start && a_sel == s) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("reach_sel", a_sel, s);
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    a_cap = 1'b0; b_cap = 1'b0; a_stray = 1'b0;
    a_thr = '0; b_thr = '0; a_esc = '0; b_esc = '0;
    a_esv = 1'b0; b_esv = 1'b0;
    a_lat = 3; b_lat = 2; a_silent = -1; b_silent = -1;
    for (int k = 0; k < 13; k++) begin
      a_tbl[k] = '0;
      b_tbl[k] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_start", a_start, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_flags", {a_nm, a_et, a_ov}, 0);
    chk("rst_rank", a_rr, 0);
    chk("rst_score", a_rs, 0);
    chk("rst_sel", a_sel, 0);
    rst = 1'b0;
    @(negedge clk);

    // Long engine latency; kernel 3 is the clear winner.
    a_lat = 1120;
    for (int k = 0; k < 13; k++) a_tbl[k] = 11'(k * 50 + 100);
    a_tbl[3] = 11'd40;
    n0 = a_st_n;
    pulse_cap(11'd200);
    chk("s1_busy", a_busy, 1);
    wait_rv(20000);
    chk("s1_rank", a_rr, 4);
    chk("s1_score", a_rs, 40);
    chk("s1_nm", a_nm, 0);
    chk("s1_et", a_et, 0);
    chk("s1_starts", a_st_n - n0, 13);
    chk("s1_cycles", a_rv_cyc - cap_cyc, 13 * (2 + 1120) + 2);
    repeat (2) @(negedge clk);
    chk("s1_idle", a_busy, 0);

    // Tie between kernels 5 and 9 resolves to the lower index.
    a_lat = 3;
    for (int k = 0; k < 13; k++) a_tbl[k] = 11'd500;
    a_tbl[5] = 11'd30;
    a_tbl[9] = 11'd30;
    pulse_cap(11'd100);
    wait_rv(500);
    chk("s2_rank", a_rr, 6);
    chk("s2_score", a_rs, 30);
    chk("s2_cycles", a_rv_cyc - cap_cyc, 13 * 5 + 2);
    repeat (2) @(negedge clk);

    for (int k = 0; k < 13; k++) a_tbl[k] = 11'd300;
    pulse_cap(11'd299);
    wait_rv(500);
    chk("s3a_nm", a_nm, 1);
    chk("s3a_rank", a_rr, 0);
    chk("s3a_score", a_rs, 300);
    repeat (2) @(negedge clk);
    pulse_cap(11'd300);
    wait_rv(500);
    chk("s3b_nm", a_nm, 0);
    chk("s3b_rank", a_rr, 1);
    repeat (2) @(negedge clk);

    // Watchdog: kernel 7 never answers on the 16-cycle instance.
    for (int k = 0; k < 13; k++) b_tbl[k] = 11'(k * 10 + 200);
    b_tbl[2] = 11'd150;
    b_silent = 7;
    b_thr = 11'd2047;
    n0 = b_rv_n;
    b_cap = 1'b1;
    @(negedge clk);
    b_cap = 1'b0;
    for (int i = 0; i < 500 && b_rv_n == n0; i++) @(negedge clk);
    chk("s4_rv_seen", b_rv_n - n0, 1);
    chk("s4_et", b_et, 1);
    chk("s4_nm", b_nm, 1);
    chk("s4_rank", b_rr, 0);
    chk("s4_score", b_rs, 150);
    // result_valid lands 17 cycles after the edge sampling start #7.
    chk("s4_latency", b_rv_cyc - b_st7_cyc, 18);
    repeat (2) @(negedge clk);
    chk("s4_idle", b_busy, 0);

    // Capture during kernel 2 WAIT is dropped and flagged.
    for (int k = 0; k < 13; k++) a_tbl[k] = 11'd500;
    a_tbl[4] = 11'd20;
    n0 = a_rv_n;
    pulse_cap(11'd100);
    wait_sel(4'd2);
    a_cap = 1'b1;
    @(negedge clk);
    a_cap = 1'b0;
    chk("s5_ov", a_ov, 1);
    wait_rv(500);
    repeat (5) @(negedge clk);
    chk("s5_single", a_rv_n - n0, 1);
    chk("s5_rank", a_rr, 5);
    chk("s5_ov_sticky", a_ov, 1);
    pulse_cap(11'd100);
    chk("s5_ov_clr", a_ov, 0);
    wait_rv(500);
    chk("s5_rank2", a_rr, 5);
    repeat (2) @(negedge clk);

    // Reset during kernel 5 WAIT aborts silently.
    for (int k = 0; k < 13; k++) a_tbl[k] = 11'(k * 20 + 100);
    a_tbl[8] = 11'd10;
    n0 = a_rv_n;
    pulse_cap(11'd100);
    wait_sel(4'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_busy", a_busy, 0);
    @(negedge clk);
    chk("s6_start", a_start, 0);
    @(posedge clk);
    #1 a_stray = 1'b1;
    @(posedge clk);
    #1 a_stray = 1'b0;
    repeat (6) @(negedge clk);
    chk("s6_no_rv", a_rv_n - n0, 0);
    chk("s6_busy2", a_busy, 0);
    chk("s6_sel", a_sel, 0);
    chk("s6_rank_rst", a_rr, 0);
    pulse_cap(11'd100);
    chk("s6_restart", {a_start, a_sel}, {1'b1, 4'd0});
    wait_rv(500);
    chk("s6_rank", a_rr, 9);
    chk("s6_score", a_rs, 10);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
